// File: rtl/pipe_fetch_pc_pkg.sv
// pipe_fetch_pc_pkg: shared fetch-stage defaults, PC update-select encoding and alignment-mask helper
package pipe_fetch_pc_pkg;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VEC = 32'h0000_0008;
  localparam int DEF_INC = 4;
  typedef enum logic [2:0] {SEL_HOLD, SEL_EXC, SEL_MIS, SEL_LIVE, SEL_PEND, SEL_SEQ} pc_sel_e;
  function automatic logic [31:0] align_mask(input int inc);
    return 32'(inc - 1);
  endfunction
endpackage

// File: rtl/pipe_redir_hold.sv
// pipe_redir_hold: pending redirect register (in: clock resetn set clear target; out: pend pend_target), clear wins over set
module pipe_redir_hold #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             set,
  input  logic             clear,
  input  logic [WIDTH-1:0] target,
  output logic             pend,
  output logic [WIDTH-1:0] pend_target
);
  always_ff @(posedge clock) begin
    if (!resetn) begin
      pend <= 1'b0;
      pend_target <= '0;
    end else if (clear) begin
      pend <= 1'b0;
    end else if (set) begin
      pend <= 1'b1;
      pend_target <= target;
    end
  end
endmodule

// File: rtl/pipe_fetch_pc.sv
// pipe_fetch_pc: fetch PC with startup hold, exception, misalign trap, pending redirect and stall (in: clock resetn wpcir redir_valid redir_target exc_valid exc_pc; out: pc pc_valid epc misalign)
module pipe_fetch_pc
  import pipe_fetch_pc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(DEF_EXC_VEC),
  parameter int               INC       = DEF_INC,
  parameter int               STARTUP   = 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             wpcir,
  input  logic             redir_valid,
  input  logic [WIDTH-1:0] redir_target,
  input  logic             exc_valid,
  input  logic [WIDTH-1:0] exc_pc,
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  output logic [WIDTH-1:0] epc,
  output logic             misalign
);
  localparam logic [WIDTH-1:0] AMASK = WIDTH'(align_mask(INC));
  logic [3:0] cnt;
  logic pend, mis, set, clear;
  logic [WIDTH-1:0] pend_target, pc_next, epc_next;
  pc_sel_e sel;
  assign mis = redir_valid && |(redir_target & AMASK);
  assign pc_valid = cnt == 4'd0;
  always_comb begin
    sel = cnt != 4'd0 ? SEL_HOLD : exc_valid ? SEL_EXC : mis ? SEL_MIS : redir_valid && wpcir ? SEL_LIVE : pend && wpcir ? SEL_PEND : wpcir ? SEL_SEQ : SEL_HOLD;
    pc_next = sel == SEL_EXC || sel == SEL_MIS ? EXC_VEC : sel == SEL_LIVE ? redir_target : sel == SEL_PEND ? pend_target : sel == SEL_SEQ ? pc + WIDTH'(INC) : pc;
    epc_next = sel == SEL_EXC ? exc_pc : sel == SEL_MIS ? redir_target : epc;
    set = sel == SEL_HOLD && cnt == 4'd0 && redir_valid;
    clear = sel inside {SEL_EXC, SEL_MIS, SEL_LIVE, SEL_PEND};
  end
  always_ff @(posedge clock) begin
    if (!resetn) begin
      pc <= RESET_VEC;
      epc <= '0;
      misalign <= 1'b0;
      cnt <= 4'(STARTUP);
    end else begin
      pc <= pc_next;
      epc <= epc_next;
      misalign <= sel == SEL_MIS;
      cnt <= cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
    end
  end
  pipe_redir_hold #(.WIDTH(WIDTH)) u_hold (
    .clock(clock),
    .resetn(resetn),
    .set(set),
    .clear(clear),
    .target(redir_target),
    .pend(pend),
    .pend_target(pend_target)
  );
endmodule

// File: tb/tb_pipe_fetch_pc.sv
// tb_pipe_fetch_pc: directed scenarios plus randomized run against a behavioural PC model, 32-bit and 8-bit instances
module tb_pipe_fetch_pc;
  logic clock = 1'b0, resetn = 1'b0, wpcir = 1'b0, redir_valid = 1'b0, exc_valid = 1'b0;
  logic [31:0] redir_target = '0, exc_pc = '0;
  logic [31:0] pc32, epc32;
  logic v32, mis32;
  logic [7:0] pc8, epc8;
  logic v8, mis8;
  int n_run = 0, n_fail = 0;
  logic [31:0] m_pc[2], m_epc[2], m_pt[2];
  logic m_mis[2], m_pend[2];
  int m_cnt[2];
  always #5 clock = ~clock;
  pipe_fetch_pc d32 (
    .clock(clock), .resetn(resetn), .wpcir(wpcir), .redir_valid(redir_valid),
    .redir_target(redir_target), .exc_valid(exc_valid), .exc_pc(exc_pc),
    .pc(pc32), .pc_valid(v32), .epc(epc32), .misalign(mis32)
  );
  pipe_fetch_pc #(.WIDTH(8)) d8 (
    .clock(clock), .resetn(resetn), .wpcir(wpcir), .redir_valid(redir_valid),
    .redir_target(redir_target[7:0]), .exc_valid(exc_valid), .exc_pc(exc_pc[7:0]),
    .pc(pc8), .pc_valid(v8), .epc(epc8), .misalign(mis8)
  );
  task automatic cyc(input logic rn, input logic w, input logic rv, input logic [31:0] rt, input logic ev, input logic [31:0] ep);
    resetn = rn; wpcir = w; redir_valid = rv; redir_target = rt; exc_valid = ev; exc_pc = ep;
    @(posedge clock);
    for (int i = 0; i < 2; i++) begin
      logic [31:0] wm, t;
      wm = i == 0 ? 32'hFFFF_FFFF : 32'h0000_00FF;
      t = rt & wm;
      m_mis[i] = 1'b0;
      if (!rn) begin m_pc[i] = 0; m_epc[i] = 0; m_pend[i] = 0; m_cnt[i] = 1; end
      else if (m_cnt[i] > 0) m_cnt[i]--;
      else if (ev) begin m_pc[i] = 8; m_epc[i] = ep & wm; m_pend[i] = 0; end
      else if (rv && t % 4 != 0) begin m_pc[i] = 8; m_epc[i] = t; m_mis[i] = 1; m_pend[i] = 0; end
      else if (rv && w) begin m_pc[i] = t; m_pend[i] = 0; end
      else if (rv) begin m_pend[i] = 1; m_pt[i] = t; end
      else if (w && m_pend[i]) begin m_pc[i] = m_pt[i]; m_pend[i] = 0; end
      else if (w) m_pc[i] = (m_pc[i] + 4) & wm;
    end
    #1;
  endtask
  task automatic test_reset();
    cyc(0, 1, 1, 32'h40, 1, 32'h1C);
    cyc(0, 1, 0, 0, 0, 0);
    n_run++; if (pc32 !== 32'h0) begin n_fail++; $display("FAIL reset pc: got %h want %h", pc32, 32'h0); end
    n_run++; if (v32 !== 1'b0) begin n_fail++; $display("FAIL reset pc_valid: got %b want 0", v32); end
    n_run++; if (epc32 !== 32'h0) begin n_fail++; $display("FAIL reset epc: got %h want 0", epc32); end
    n_run++; if (mis32 !== 1'b0) begin n_fail++; $display("FAIL reset misalign: got %b want 0", mis32); end
    n_run++; if (pc8 !== 8'h0) begin n_fail++; $display("FAIL reset pc8: got %h want 0", pc8); end
  endtask
  task automatic test_startup();
    for (int k = 0; k < 4; k++) begin
      cyc(1, 1, 0, 0, 0, 0);
      n_run++; if (pc32 !== 32'(4 * k) || v32 !== 1'b1) begin n_fail++; $display("FAIL startup step %0d: got pc %h valid %b want pc %h valid 1", k, pc32, v32, 4 * k); end
    end
  endtask
  task automatic test_stall_redirect();
    cyc(1, 0, 1, 32'h40, 0, 0);
    n_run++; if (pc32 !== 32'hC) begin n_fail++; $display("FAIL stall_redir hold0: got %h want %h", pc32, 32'hC); end
    for (int k = 1; k < 3; k++) begin
      cyc(1, 0, 0, 0, 0, 0);
      n_run++; if (pc32 !== 32'hC) begin n_fail++; $display("FAIL stall_redir hold%0d: got %h want %h", k, pc32, 32'hC); end
    end
    cyc(1, 1, 0, 0, 0, 0);
    n_run++; if (pc32 !== 32'h40) begin n_fail++; $display("FAIL stall_redir apply: got %h want %h", pc32, 32'h40); end
    cyc(1, 1, 0, 0, 0, 0);
    n_run++; if (pc32 !== 32'h44) begin n_fail++; $display("FAIL stall_redir next: got %h want %h", pc32, 32'h44); end
  endtask
  task automatic test_exception();
    cyc(1, 0, 1, 32'h40, 0, 0);
    n_run++; if (pc32 !== 32'h44) begin n_fail++; $display("FAIL exc pend hold: got %h want %h", pc32, 32'h44); end
    cyc(1, 0, 0, 0, 1, 32'h1C);
    n_run++; if (pc32 !== 32'h8 || epc32 !== 32'h1C) begin n_fail++; $display("FAIL exc load: got pc %h epc %h want pc 8 epc 1c", pc32, epc32); end
    cyc(1, 1, 0, 0, 0, 0);
    n_run++; if (pc32 !== 32'hC) begin n_fail++; $display("FAIL exc discard pending: got %h want %h", pc32, 32'hC); end
  endtask
  task automatic test_misalign();
    cyc(1, 1, 1, 32'h42, 0, 0);
    n_run++; if (pc32 !== 32'h8 || epc32 !== 32'h42 || mis32 !== 1'b1) begin n_fail++; $display("FAIL misalign trap: got pc %h epc %h mis %b want pc 8 epc 42 mis 1", pc32, epc32, mis32); end
    cyc(1, 1, 0, 0, 0, 0);
    n_run++; if (pc32 !== 32'hC || epc32 !== 32'h42 || mis32 !== 1'b0) begin n_fail++; $display("FAIL misalign pulse end: got pc %h epc %h mis %b want pc c epc 42 mis 0", pc32, epc32, mis32); end
  endtask
  task automatic test_wrap();
    cyc(1, 1, 1, 32'hFC, 0, 0);
    n_run++; if (pc8 !== 8'hFC || pc32 !== 32'hFC) begin n_fail++; $display("FAIL wrap setup: got pc8 %h pc32 %h want fc fc", pc8, pc32); end
    cyc(1, 1, 0, 0, 0, 0);
    n_run++; if (pc8 !== 8'h00) begin n_fail++; $display("FAIL wrap pc8: got %h want 00", pc8); end
    n_run++; if (pc32 !== 32'h100) begin n_fail++; $display("FAIL wrap pc32: got %h want %h", pc32, 32'h100); end
  endtask
  task automatic test_mid_reset();
    cyc(1, 0, 1, 32'h80, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    n_run++; if (pc32 !== 32'h0 || v32 !== 1'b0) begin n_fail++; $display("FAIL midreset load: got pc %h valid %b want 0 0", pc32, v32); end
    for (int k = 0; k < 3; k++) begin
      cyc(1, 1, 0, 0, 0, 0);
      n_run++; if (pc32 !== 32'(4 * k)) begin n_fail++; $display("FAIL midreset step %0d: got %h want %h", k, pc32, 4 * k); end
    end
  endtask
  task automatic test_random();
    cyc(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 400; k++) begin
      logic [31:0] rt;
      rt = ($urandom & 32'hFFFF_FFFC) | ($urandom_range(0, 4) == 0 ? 32'($urandom_range(1, 3)) : 32'h0);
      cyc($urandom_range(0, 49) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, rt, $urandom_range(0, 19) == 0, $urandom);
      n_run++;
      if ({pc32, v32, epc32, mis32} !== {m_pc[0], m_cnt[0] == 0, m_epc[0], m_mis[0]}) begin
        n_fail++; $display("FAIL random32 cyc %0d: got pc %h v %b epc %h mis %b want pc %h v %b epc %h mis %b", k, pc32, v32, epc32, mis32, m_pc[0], m_cnt[0] == 0, m_epc[0], m_mis[0]);
      end
      n_run++;
      if ({pc8, v8, epc8, mis8} !== {m_pc[1][7:0], m_cnt[1] == 0, m_epc[1][7:0], m_mis[1]}) begin
        n_fail++; $display("FAIL random8 cyc %0d: got pc %h v %b epc %h mis %b want pc %h v %b epc %h mis %b", k, pc8, v8, epc8, mis8, m_pc[1][7:0], m_cnt[1] == 0, m_epc[1][7:0], m_mis[1]);
      end
    end
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin m_pc[i] = 0; m_epc[i] = 0; m_pt[i] = 0; m_mis[i] = 0; m_pend[i] = 0; m_cnt[i] = 1; end
    test_reset();
    test_startup();
    test_stall_redirect();
    test_exception();
    test_misalign();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
